// File: rtl/cmp_pkg.sv
// Shared encodings for the chunked comparator: FSM states and the {gt,lt,eq} result flags.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } cmp_state_e;

  localparam logic [2:0] GT   = 3'b100;
  localparam logic [2:0] LT   = 3'b010;
  localparam logic [2:0] EQ   = 3'b001;
  localparam logic [2:0] NONE = 3'b000;

  function automatic logic [2:0] encode_flags(input logic gt_i, input logic lt_i);
    logic [2:0] f;
    if (gt_i) begin
      f = GT;
    end else if (lt_i) begin
      f = LT;
    end else begin
      f = EQ;
    end
    return f;
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational unsigned magnitude compare of one CHUNK-bit slice.
module cmp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/chunk_comparer.sv
// Multi-cycle signed/unsigned comparator: walks the operands MSB chunk first and
// exits as soon as a slice differs.
module chunk_comparer
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  localparam int SAFE_CHUNK = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NCHUNK     = WIDTH / SAFE_CHUNK;
  localparam int IDXW       = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NCHUNK - 1);
  localparam logic [CHUNK-1:0] TOP_MASK = CHUNK'(1'b1) << (CHUNK - 1);

  if (CHUNK < 1) begin : g_bad_chunk
    $error("chunk_comparer: CHUNK must be at least 1");
  end else if ((WIDTH % SAFE_CHUNK) != 0) begin : g_bad_width
    $error("chunk_comparer: WIDTH must be a multiple of CHUNK");
  end

  cmp_state_e       state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             signed_r;
  logic [IDXW-1:0]  idx_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [2:0]       flags_r;

  logic [CHUNK-1:0] slice_a_s;
  logic [CHUNK-1:0] slice_b_s;
  logic [CHUNK-1:0] flip_s;
  logic             gt_s;
  logic             lt_s;
  logic             eq_s;

  // Flipping the sign bit of the top slice maps two's-complement order onto unsigned order.
  assign flip_s    = (signed_r && (idx_r == LAST_IDX)) ? TOP_MASK : {CHUNK{1'b0}};
  assign slice_a_s = a_r[idx_r*CHUNK +: CHUNK] ^ flip_s;
  assign slice_b_s = b_r[idx_r*CHUNK +: CHUNK] ^ flip_s;

  cmp_chunk #(.CHUNK(CHUNK)) u_cmp_chunk (
    .a  (slice_a_s),
    .b  (slice_b_s),
    .gt (gt_s),
    .lt (lt_s),
    .eq (eq_s)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      signed_r    <= 1'b0;
      idx_r       <= LAST_IDX;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      flags_r     <= NONE;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            a_r        <= a;
            b_r        <= b;
            signed_r   <= is_signed;
            idx_r      <= LAST_IDX;
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        RUN: begin
          if (!eq_s) begin
            flags_r     <= encode_flags(gt_s, lt_s);
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else if (idx_r == {IDXW{1'b0}}) begin
            flags_r     <= EQ;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            idx_r <= idx_r - IDXW'(1'b1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            flags_r     <= NONE;
            in_ready_r  <= 1'b1;
            idx_r       <= LAST_IDX;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          idx_r       <= LAST_IDX;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          flags_r     <= NONE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign gt        = flags_r[2];
  assign lt        = flags_r[1];
  assign eq        = flags_r[0];

endmodule

// File: tb/tb_chunk_comparer.sv
// Directed self-checking bench for chunk_comparer (WIDTH=32, CHUNK=8).
module tb_chunk_comparer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic        gt;
  logic        lt;
  logic        eq;

  int checks;
  int failures;

  chunk_comparer #(.WIDTH(32), .CHUNK(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gt        (gt),
    .lt        (lt),
    .eq        (eq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transaction: offer, scramble inputs while busy, measure latency, optional backpressure.
  task automatic run_cmp(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic vs, input logic [2:0] exp_f, input int exp_lat,
                         input bit early, input bit bp);
    int n;
    int lat;
    logic [2:0] held;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    a = va; b = vb; is_signed = vs; in_valid = 1'b1; out_ready = early;
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~va; b = va ^ 32'h5A5A_A5A5; is_signed = ~vs;
    lat = 0;
    while (!out_valid && lat < 12) begin
      check({tag, "_busy_flags"}, {28'd0, in_ready, gt, lt, eq}, 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_flags"}, {29'd0, gt, lt, eq}, {29'd0, exp_f});
    if (bp) begin
      held = {gt, lt, eq};
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        check({tag, "_bp_hold"}, {27'd0, in_ready, out_valid, gt, lt, eq}, {27'd0, 1'b0, 1'b1, held});
      end
    end
    if (!early) begin
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_to_idle"}, {27'd0, in_ready, out_valid, gt, lt, eq}, 32'h10);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; in_valid = 1'b0; a = 32'd0; b = 32'd0; is_signed = 1'b0; out_ready = 1'b0;
    #1;
    check("reset_outputs", {27'd0, in_ready, out_valid, gt, lt, eq}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", {31'd0, in_ready}, 32'd1);

    run_cmp("u_msb",     32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 3'b100, 1, 1'b0, 1'b0);
    run_cmp("s_msb",     32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b010, 1, 1'b0, 1'b0);
    run_cmp("s_neg_lsb", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 3'b100, 4, 1'b0, 1'b0);
    run_cmp("u_eq",      32'h1234_5678, 32'h1234_5678, 1'b0, 3'b001, 4, 1'b0, 1'b0);
    run_cmp("s_eq",      32'h1234_5678, 32'h1234_5678, 1'b1, 3'b001, 4, 1'b0, 1'b0);
    run_cmp("u_chunk2",  32'h0001_0000, 32'h0000_0000, 1'b0, 3'b100, 2, 1'b0, 1'b0);
    run_cmp("s_mixed",   32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 3'b100, 1, 1'b0, 1'b0);
    run_cmp("u_mixed",   32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 3'b010, 1, 1'b0, 1'b0);
    run_cmp("s_bothneg", 32'h8000_0000, 32'h8000_0001, 1'b1, 3'b010, 4, 1'b0, 1'b0);
    run_cmp("u_chunk1",  32'h0000_0100, 32'h0000_0200, 1'b0, 3'b010, 3, 1'b0, 1'b0);
    run_cmp("bp",        32'h00AB_0000, 32'h00AC_0000, 1'b0, 3'b010, 2, 1'b0, 1'b1);
    run_cmp("b2b",       32'h7F00_0000, 32'h7E00_0000, 1'b1, 3'b100, 1, 1'b0, 1'b0);
    run_cmp("early_rdy", 32'h0000_0003, 32'h0000_0002, 1'b0, 3'b100, 4, 1'b1, 1'b0);

    a = 32'hCAFE_F00D; b = 32'hCAFE_F00D; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", {27'd0, in_ready, out_valid, gt, lt, eq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_reset_release", {27'd0, in_ready, out_valid, gt, lt, eq}, 32'h10);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("no_stale_result", {31'd0, out_valid}, 32'd0);
    end
    run_cmp("post_reset", 32'h0000_0000, 32'h0000_0001, 1'b1, 3'b010, 4, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/chunk_comparer.md
CHUNK_COMPARER -- requirements
Module: chunk_comparer

Interface
REQ-001 Parameter WIDTH, default 32, is the operand width in bits.
REQ-002 Parameter CHUNK, default 8, is the number of bits compared per clock cycle; NCHUNK = WIDTH/CHUNK.
REQ-003 Port clk  input  1  is the single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1  is the reset: asynchronous, active-low.
REQ-005 Port in_valid  input  1  means the operand set on a, b and is_signed is offered.
REQ-006 Port in_ready  output  1  means the block accepts an operand set this cycle.
REQ-007 Port a  input  WIDTH  is the first operand.
REQ-008 Port b  input  WIDTH  is the second operand.
REQ-009 Port is_signed  input  1  selects the mode: 1 = two's-complement, 0 = unsigned.
REQ-010 Port out_valid  output  1  means gt, lt and eq hold a valid result.
REQ-011 Port out_ready  input  1  means the consumer takes the result this cycle.
REQ-012 Ports gt, lt, eq  output  1 each  are the result flags: a>b, a<b, a==b.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 in_ready SHALL be registered and SHALL be 1 only in IDLE.
REQ-015 Acceptance SHALL be the cycle with in_valid&in_ready in IDLE; a, b and is_signed are captured into internal registers and the FSM moves to RUN with chunk index NCHUNK-1 (MSB chunk).
REQ-016 Each RUN cycle SHALL compare one CHUNK-bit slice of the captured operands as unsigned values, starting at the MSB chunk and working down.
REQ-017 On the MSB chunk with signed mode captured, the top bit of both slices SHALL be inverted before comparison, so the signed result is correct in all cases, including mixed signs.
REQ-018 A differing slice SHALL register gt or lt, set out_valid and move to DONE (early exit).
REQ-019 An equal slice at index 0 SHALL register eq=1 and move to DONE; an equal slice at any other index SHALL decrement the index and stay in RUN.
REQ-020 Latency from acceptance to out_valid=1 SHALL be k cycles, where k = (NCHUNK - index of the highest differing chunk); k = NCHUNK for equal operands.
REQ-021 When out_valid=1, exactly one of gt, lt, eq SHALL be 1; when out_valid=0, all three SHALL be 0.
REQ-022 In DONE, out_valid and the flags SHALL hold stable until out_ready=1, then return to IDLE on the next edge, with in_ready=1 and out_valid=0.
REQ-023 out_ready=1 in the same cycle out_valid first rises SHALL complete the transfer in that cycle.
REQ-024 Changes on a, b, is_signed or in_valid during RUN or DONE SHALL have no effect.
REQ-025 With CHUNK==WIDTH, every compare SHALL complete in 1 cycle.
REQ-026 WIDTH not a multiple of CHUNK, or CHUNK<1, SHALL be an elaboration-time error.

Reset
REQ-027 With rst_n=0: state=IDLE, in_ready=0, out_valid=0, gt=lt=eq=0, chunk index=NCHUNK-1, operand registers=0.
REQ-028 in_ready SHALL rise on the first clock edge after rst_n deasserts.
REQ-029 Reset asserted during RUN or DONE SHALL discard the operation with no partial result.

Structure
REQ-030 A shared package cmp_pkg SHALL hold the state encoding (IDLE/RUN/DONE) and the result-flag encoding constants (GT=3'b100, LT=3'b010, EQ=3'b001, ordered {gt,lt,eq}).
REQ-031 A combinational sub-module cmp_chunk (CHUNK-bit unsigned gt/lt/eq) SHALL be instantiated once and fed the muxed current slice.

Verification (WIDTH=32, CHUNK=8)
REQ-032 Unsigned: a=0x80000000, b=0x7FFFFFFF -> gt=1, out_valid 1 cycle after acceptance.
REQ-033 Signed: same operands -> lt=1 after 1 cycle; a=0xFFFFFFFF, b=0xFFFFFFFE -> gt=1 after 4 cycles.
REQ-034 a=b=0x12345678 (either mode) -> eq=1 after 4 cycles; a=0x00010000, b=0 -> gt=1 after 2 cycles.
REQ-035 Backpressure: out_ready held 0 for 5 cycles -> out_valid and the flags stay stable and in_ready stays 0; out_ready=1 -> IDLE next cycle; the next transaction is accepted back-to-back.
REQ-036 Operands changed mid-RUN -> result reflects the captured values only.
REQ-037 rst_n pulsed low mid-RUN -> all outputs 0 immediately; in_ready=1 one edge after release; no stale out_valid.
